// File: rtl/fp_addsub_param.sv
// Multi-cycle parametrised floating-point adder/subtractor, one operation in flight at a time.
// Results take 10+ cycles (3 for special operands); in_ready is high only in IDLE, and the result is held until out_ready.
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 in_sub,
    input  logic                 in_rnd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_z,
    output logic                 out_invalid,
    output logic                 out_overflow,
    output logic                 out_inexact
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMIN  = EW'(2 - (1 << (EXP_W - 1)));
    localparam logic signed [EW-1:0] BIG_D = EW'(MAN_W + 3);
    localparam logic signed [EW-1:0] ONE   = EW'(1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE, S_UNPACK, S_SPECIAL, S_ALIGN, S_ADD, S_ADDN,
        S_NORM_L, S_NORM_R, S_ROUND, S_PACK, S_OUT
    } state_t;

    state_t                state;
    logic [W-1:0]          a_r, b_r;
    logic                  sub_r, rnd_r, sa, sb, rs, inx;
    logic signed [EW-1:0]  ea, eb, re;
    logic [MW-1:0]         ma, mb, mr;
    logic [MW:0]           msum;

    logic [EXP_W-1:0]      a_fld, b_fld, pack_f;
    logic [MAN_W-1:0]      a_frc, b_frc;
    logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, rnd_inc;
    logic signed [EW-1:0]  ediff, ndiff;
    logic [MAN_W+1:0]      rounded;

    function automatic logic signed [EW-1:0] unbias(input logic [EXP_W-1:0] f);
        return (f == '0) ? EMIN : $signed({2'b00, f}) - BIAS;
    endfunction

    assign in_ready = (state == S_IDLE);
    assign a_fld    = a_r[W-2:MAN_W];
    assign b_fld    = b_r[W-2:MAN_W];
    assign a_frc    = a_r[MAN_W-1:0];
    assign b_frc    = b_r[MAN_W-1:0];
    assign a_nan    = (&a_fld) && (|a_frc);
    assign b_nan    = (&b_fld) && (|b_frc);
    assign a_inf    = (&a_fld) && !(|a_frc);
    assign b_inf    = (&b_fld) && !(|b_frc);
    assign a_zero   = !(|a_fld) && !(|a_frc);
    assign b_zero   = !(|b_fld) && !(|b_frc);
    assign ediff    = ea - eb;
    assign ndiff    = eb - ea;
    // mr[2:0] are guard, round and sticky; mr[3] is the result LSB
    assign rnd_inc  = !rnd_r && mr[2] && (mr[1] || mr[0] || mr[3]);
    assign rounded  = {1'b0, mr[MW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_inc};
    assign pack_f   = re[EXP_W-1:0] + BIAS[EXP_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            a_r          <= '0;
            b_r          <= '0;
            sub_r        <= 1'b0;
            rnd_r        <= 1'b0;
            sa           <= 1'b0;
            sb           <= 1'b0;
            rs           <= 1'b0;
            inx          <= 1'b0;
            ea           <= '0;
            eb           <= '0;
            re           <= '0;
            ma           <= '0;
            mb           <= '0;
            mr           <= '0;
            msum         <= '0;
            out_valid    <= 1'b0;
            out_z        <= '0;
            out_invalid  <= 1'b0;
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    a_r   <= in_a;
                    b_r   <= in_b;
                    sub_r <= in_sub;
                    rnd_r <= in_rnd;
                    state <= S_UNPACK;
                end
                S_UNPACK: begin
                    sa    <= a_r[W-1];
                    sb    <= b_r[W-1] ^ sub_r;
                    ea    <= unbias(a_fld);
                    eb    <= unbias(b_fld);
                    ma    <= {|a_fld, a_frc, 3'b000};
                    mb    <= {|b_fld, b_frc, 3'b000};
                    state <= S_SPECIAL;
                end
                S_SPECIAL: begin
                    out_invalid  <= 1'b0;
                    out_overflow <= 1'b0;
                    out_inexact  <= 1'b0;
                    state        <= S_OUT;
                    if (a_nan || b_nan || (a_inf && b_inf && sa != sb)) begin
                        out_z       <= QNAN;
                        out_invalid <= 1'b1;
                    end else if (a_inf) out_z <= {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    else if (b_inf) out_z <= {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    else if (a_zero && b_zero) out_z <= {sa & sb, {(W-1){1'b0}}};
                    else if (a_zero) out_z <= {sb, b_r[W-2:0]};
                    else if (b_zero) out_z <= a_r;
                    else state <= S_ALIGN;
                end
                S_ALIGN: begin
                    if (ediff == '0) begin
                        state <= S_ADD;
                    end else if (!ediff[EW-1]) begin
                        if (ediff > BIG_D) begin
                            mb <= {{(MW-1){1'b0}}, |mb};
                            eb <= ea;
                        end else begin
                            mb <= {1'b0, mb[MW-1:2], mb[1] | mb[0]};
                            eb <= eb + ONE;
                        end
                    end else begin
                        if (ndiff > BIG_D) begin
                            ma <= {{(MW-1){1'b0}}, |ma};
                            ea <= eb;
                        end else begin
                            ma <= {1'b0, ma[MW-1:2], ma[1] | ma[0]};
                            ea <= ea + ONE;
                        end
                    end
                end
                S_ADD: begin
                    re <= ea;
                    if (sa == sb) begin
                        msum <= {1'b0, ma} + {1'b0, mb};
                        rs   <= sa;
                    end else if (ma >= mb) begin
                        msum <= {1'b0, ma - mb};
                        rs   <= (ma == mb) ? 1'b0 : sa;
                    end else begin
                        msum <= {1'b0, mb - ma};
                        rs   <= sb;
                    end
                    state <= S_ADDN;
                end
                S_ADDN: begin
                    if (msum[MW]) begin
                        mr <= {msum[MW:2], msum[1] | msum[0]};
                        re <= re + ONE;
                    end else begin
                        mr <= msum[MW-1:0];
                    end
                    state <= S_NORM_L;
                end
                S_NORM_L: begin
                    if (!mr[MW-1] && re > EMIN) begin
                        mr <= {mr[MW-2:0], 1'b0};
                        re <= re - ONE;
                    end else begin
                        state <= S_NORM_R;
                    end
                end
                S_NORM_R: begin
                    if (re < EMIN) begin
                        mr <= {1'b0, mr[MW-1:2], mr[1] | mr[0]};
                        re <= re + ONE;
                    end else begin
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    inx <= |mr[2:0];
                    if (rounded[MAN_W+1]) begin
                        mr <= {rounded[MAN_W+1:1], 3'b000};
                        re <= re + ONE;
                    end else begin
                        mr <= {rounded[MAN_W:0], 3'b000};
                    end
                    state <= S_PACK;
                end
                S_PACK: begin
                    out_invalid <= 1'b0;
                    if (mr[MW-1] && re > BIAS) begin
                        out_overflow <= 1'b1;
                        out_inexact  <= 1'b1;
                        out_z <= rnd_r ? {rs, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                                       : {rs, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else begin
                        out_overflow <= 1'b0;
                        out_inexact  <= inx;
                        out_z <= {rs, mr[MW-1] ? pack_f : {EXP_W{1'b0}}, mr[MW-2:3]};
                    end
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_param.sv
// Bench for fp_addsub_param: single-precision and half-precision instances, directed cases and random ops
// checked against an exact-integer rounding model.
module tb_fp_addsub_param;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_in_valid, s_in_ready, s_in_sub, s_in_rnd, s_out_valid, s_out_ready;
    logic        s_inv, s_ovf, s_inx;
    logic [31:0] s_a, s_b, s_z;
    logic        h_in_valid, h_in_ready, h_in_sub, h_in_rnd, h_out_valid, h_out_ready;
    logic        h_inv, h_ovf, h_inx;
    logic [15:0] h_a, h_b, h_z;

    fp_addsub_param dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_a), .in_b(s_b), .in_sub(s_in_sub), .in_rnd(s_in_rnd),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_z(s_z),
        .out_invalid(s_inv), .out_overflow(s_ovf), .out_inexact(s_inx)
    );

    fp_addsub_param #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in_a(h_a), .in_b(h_b), .in_sub(h_in_sub), .in_rnd(h_in_rnd),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .out_z(h_z),
        .out_invalid(h_inv), .out_overflow(h_ovf), .out_inexact(h_inx)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [63:0] r_res;
    int          r_lat;

    function automatic logic [63:0] res(input logic [31:0] z, input bit iv, input bit ov, input bit ix);
        return {29'd0, z, iv, ov, ix};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Exact model: both operands scaled to integers in units of the smallest subnormal,
    // summed exactly, then rounded back to the format. Returns {z, invalid, overflow, inexact}.
    function automatic logic [34:0] ref_add(input int ew, input int mw, input logic [31:0] a,
                                            input logic [31:0] b, input bit sub, input bit rnd);
        logic [31:0]  emax, fmask, ea, eb, fa, fb, qnan, infp, smask, sgn, fld;
        logic [299:0] ma, mb, s, kept, rem, half;
        bit           sa, sb, rs, na, nb, ia, ib, za, zb, inx;
        int           p, sh;
        emax  = (32'd1 << ew) - 1;
        fmask = (32'd1 << mw) - 1;
        ea = (a >> mw) & emax;  eb = (b >> mw) & emax;
        fa = a & fmask;         fb = b & fmask;
        sa = a[ew+mw];          sb = b[ew+mw] ^ sub;
        qnan  = (emax << mw) | (32'd1 << (mw - 1));
        infp  = emax << mw;
        smask = 32'd1 << (ew + mw);
        na = (ea == emax) && (fa != 0);  nb = (eb == emax) && (fb != 0);
        ia = (ea == emax) && (fa == 0);  ib = (eb == emax) && (fb == 0);
        za = (ea == 0) && (fa == 0);     zb = (eb == 0) && (fb == 0);
        if (na || nb || (ia && ib && sa != sb)) return {qnan, 3'b100};
        if (ia) return {(sa ? smask : 32'd0) | infp, 3'b000};
        if (ib) return {(sb ? smask : 32'd0) | infp, 3'b000};
        if (za && zb) return {((sa && sb) ? smask : 32'd0), 3'b000};
        if (za) return {(b & ~smask) | (sb ? smask : 32'd0), 3'b000};
        if (zb) return {a, 3'b000};
        ma = 300'(fa | ((ea != 0) ? (32'd1 << mw) : 32'd0)) << ((ea != 0) ? ea - 1 : 32'd0);
        mb = 300'(fb | ((eb != 0) ? (32'd1 << mw) : 32'd0)) << ((eb != 0) ? eb - 1 : 32'd0);
        if (sa == sb) begin s = ma + mb; rs = sa; end
        else if (ma >= mb) begin s = ma - mb; rs = (s != 0) && sa; end
        else begin s = mb - ma; rs = sb; end
        if (s == 0) return {32'd0, 3'b000};
        p = 0;
        for (int i = 0; i < 300; i++) if (s[i]) p = i;
        sh   = (p > mw) ? p - mw : 0;
        kept = s >> sh;
        rem  = s - (kept << sh);
        half = (sh > 0) ? (300'd1 << (sh - 1)) : 300'd0;
        inx  = (rem != 0);
        if (!rnd && sh > 0 && (rem > half || (rem == half && kept[0]))) kept = kept + 1;
        if (kept[mw+1]) begin kept = kept >> 1; sh = sh + 1; end
        sgn = rs ? smask : 32'd0;
        fld = kept[mw] ? 32'(sh + 1) : 32'd0;
        if (fld >= emax)
            return {sgn | (rnd ? (((emax - 1) << mw) | fmask) : infp), 3'b011};
        return {sgn | (fld << mw) | (kept[31:0] & fmask), 2'b00, inx};
    endfunction

    function automatic logic [31:0] mk(input int ew, input int mw, input bit s, input int e,
                                       input logic [31:0] f);
        return (32'(s) << (ew + mw)) | (32'(e) << mw) | (f & ((32'd1 << mw) - 1));
    endfunction

    task automatic send(input bit hf, input logic [31:0] a, input logic [31:0] b,
                        input bit sub, input bit rnd);
        chk("in_ready_before_op", 64'(hf ? h_in_ready : s_in_ready), 64'd1);
        if (hf) begin
            h_a = a[15:0]; h_b = b[15:0]; h_in_sub = sub; h_in_rnd = rnd; h_in_valid = 1'b1;
        end else begin
            s_a = a; s_b = b; s_in_sub = sub; s_in_rnd = rnd; s_in_valid = 1'b1;
        end
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        h_in_valid = 1'b0;
    endtask

    task automatic recv(input bit hf, input int hold);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(hf ? h_out_valid : s_out_valid) && n < 1500);
        r_lat = n;
        chk("out_valid_arrives", 64'(hf ? h_out_valid : s_out_valid), 64'd1);
        r_res = hf ? res({16'd0, h_z}, h_inv, h_ovf, h_inx) : res(s_z, s_inv, s_ovf, s_inx);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_result", res(s_z, s_inv, s_ovf, s_inx), r_res);
            chk("hold_out_valid", 64'(s_out_valid), 64'd1);
            chk("hold_in_ready", 64'(s_in_ready), 64'd0);
        end
        if (hf) h_out_ready = 1'b1; else s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        h_out_ready = 1'b0;
        chk("out_valid_drops", 64'(hf ? h_out_valid : s_out_valid), 64'd0);
    endtask

    logic [31:0] ra, rb, rt;
    logic [34:0] rexp;
    bit          rhf, rsub, rrnd;
    int          rew, rmw, remax, rea, mode;

    initial begin
        rst = 1'b0;
        s_in_valid = 0; s_in_sub = 0; s_in_rnd = 0; s_out_ready = 0; s_a = '0; s_b = '0;
        h_in_valid = 0; h_in_sub = 0; h_in_rnd = 0; h_out_ready = 0; h_a = '0; h_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(s_out_valid), 64'd0);
        chk("reset_result", res(s_z, s_inv, s_ovf, s_inx), 64'd0);
        chk("reset_in_ready", 64'(s_in_ready), 64'd1);
        chk("reset_h_result", res({16'd0, h_z}, h_inv, h_ovf, h_inx), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        send(0, 32'h3F800000, 32'h40000000, 0, 0); recv(0, 0);
        chk("one_plus_two", r_res, res(32'h40400000, 0, 0, 0));
        chk("one_plus_two_lat", 64'(r_lat), 64'd11);

        send(0, 32'h3F800000, 32'h3F800000, 1, 0); recv(0, 0);
        chk("one_minus_one", r_res, res(32'h00000000, 0, 0, 0));

        send(0, 32'h7F800000, 32'h7F800000, 1, 0); recv(0, 0);
        chk("inf_minus_inf", r_res, res(32'h7FC00000, 1, 0, 0));
        chk("special_lat", 64'(r_lat), 64'd3);

        send(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 0); recv(0, 0);
        chk("max_plus_max_rne", r_res, res(32'h7F800000, 0, 1, 1));
        send(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 1); recv(0, 0);
        chk("max_plus_max_rtz", r_res, res(32'h7F7FFFFF, 0, 1, 1));

        send(0, 32'h00000001, 32'h00000001, 0, 0); recv(0, 0);
        chk("subnormal_sum", r_res, res(32'h00000002, 0, 0, 0));

        send(0, 32'h3F800000, 32'h33800000, 0, 0); recv(0, 0);
        chk("tie_to_even", r_res, res(32'h3F800000, 0, 0, 1));
        chk("tie_to_even_lat", 64'(r_lat), 64'd34);

        send(0, 32'h3F800000, 32'h40000000, 0, 0); recv(0, 5);
        chk("held_result", r_res, res(32'h40400000, 0, 0, 0));

        // Abort an operation during its alignment shifts
        send(0, 32'h3F800000, 32'h3B800000, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 64'(s_out_valid), 64'd0);
        chk("abort_in_ready", 64'(s_in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_result", 64'(s_out_valid), 64'd0);
        send(0, 32'h3F800000, 32'h40000000, 0, 0); recv(0, 0);
        chk("after_abort", r_res, res(32'h40400000, 0, 0, 0));

        send(1, 32'h3C00, 32'h3C00, 0, 0); recv(1, 0);
        chk("half_one_plus_one", r_res, res(32'h4000, 0, 0, 0));
        send(1, 32'h7BFF, 32'h7BFF, 0, 1); recv(1, 0);
        chk("half_max_rtz", r_res, res(32'h7BFF, 0, 1, 1));

        for (int i = 0; i < 90; i++) begin
            rhf   = (i >= 60);
            rew   = rhf ? 5 : 8;
            rmw   = rhf ? 10 : 23;
            remax = (1 << rew) - 1;
            rsub  = 1'($urandom_range(0, 1));
            rrnd  = 1'($urandom_range(0, 1));
            rea   = int'($urandom_range(0, remax - 1));
            ra    = mk(rew, rmw, 1'($urandom_range(0, 1)), rea, $urandom);
            mode  = int'($urandom_range(0, 3));
            case (mode)
                0: rb = mk(rew, rmw, 1'($urandom_range(0, 1)), int'($urandom_range(0, remax)), $urandom);
                1: rb = ra ^ 32'($urandom_range(0, 255)) ^ (32'($urandom_range(0, 1)) << (rew + rmw));
                2: rb = mk(rew, rmw, 1'($urandom_range(0, 1)),
                           (rea > int'($urandom_range(0, rmw + 6))) ? rea - int'($urandom_range(0, rmw + 6)) : 0,
                           $urandom);
                default: rb = mk(rew, rmw, 1'($urandom_range(0, 1)),
                                 ($urandom_range(0, 1) != 0) ? remax : 0,
                                 ($urandom_range(0, 1) != 0) ? $urandom : 32'd0);
            endcase
            if ($urandom_range(0, 1) != 0) begin rt = ra; ra = rb; rb = rt; end
            rexp = ref_add(rew, rmw, ra, rb, rsub, rrnd);
            send(rhf, ra, rb, rsub, rrnd);
            recv(rhf, 0);
            chk($sformatf("rand%0d a=%h b=%h sub=%0d rnd=%0d", i, ra, rb, rsub, rrnd),
                r_res, {29'd0, rexp});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fp_addsub_param.md
# fp_addsub_param

Parametrised, multi-cycle IEEE-754-style floating-point adder/subtractor with valid/ready handshakes, selectable rounding mode and exception flags. It succeeds the single-precision FPU adder. It sits in the FPU datapath between the operand issue logic and the result writeback. One operation is in flight at a time. Any exponent/mantissa split is supported, e.g. half, single or custom formats.

## Interface
Parameters:
- EXP_W, 8, exponent field width (≥3).
- MAN_W, 23, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_sub  in  1  1 = compute A−B (B sign inverted), 0 = A+B.
- in_rnd  in  1  0 = round-to-nearest-even, 1 = round-toward-zero.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out_z  out  W  result.
- out_invalid  out  1  invalid-operation flag (NaN input or ∞−∞).
- out_overflow  out  1  result exponent exceeded the max finite value.
- out_inexact  out  1  rounding discarded nonzero bits, or overflow occurred.

## Operation
- Bias = 2^(EXP_W−1)−1. Internal exponent is EXP_W+2 bits signed. Internal mantissa is MAN_W+4 bits: hidden bit, fraction, guard, round, sticky. Sum is MAN_W+5 bits.
- The FSM runs IDLE → UNPACK → SPECIAL → ALIGN → ADD → ADDN → NORM_L → NORM_R → ROUND → PACK → OUT → IDLE. SPECIAL may branch directly to OUT.
- IDLE: in_valid&&in_ready latches in_a, in_b, in_sub, in_rnd. Effective B sign = b_sign^in_sub.
- SPECIAL: first matching rule wins, and the result goes to OUT.
  - Any NaN operand → canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0); invalid=1.
  - ∞ and ∞ with opposite effective signs → canonical qNaN; invalid=1.
  - ∞ and ∞ with equal signs, or a single ∞ → ∞ with that sign.
  - Both zero → zero; sign = sign_a & sign_b_eff.
  - One zero → the other operand unchanged (sign_b_eff applied if B is returned).
- Otherwise the FSM goes to ALIGN. Subnormal inputs use exponent 1−bias with hidden bit 0.
- ALIGN: the smaller-exponent mantissa shifts right 1 per cycle; the bit shifted out ORs into sticky. If the exponent difference > MAN_W+3, a single cycle replaces that mantissa by sticky-only (value 1 if nonzero) and equalises the exponents.
- ADD: equal signs → magnitude sum. Different signs → larger magnitude minus smaller; sign taken from the larger. An exact-zero difference produces +0 in either rounding mode.
- ADDN: on carry-out, shift right 1, exponent +1, fold the low bits into sticky.
- NORM_L: while hidden bit is 0 and exponent > 1−bias, shift left 1 per cycle, shifting guard into the LSB.
- NORM_R: while exponent < 1−bias, shift right 1 per cycle with sticky accumulation.
- ROUND:
  - RNE: increment when guard & (round|sticky|lsb).
  - RTZ: never increment.
  - Mantissa overflow from rounding → exponent +1.
  - inexact = guard|round|sticky.
- PACK:
  - Exponent field = exp+bias; 0 if the hidden bit is 0 (subnormal/zero).
  - If the exponent exceeds the max finite value: overflow=1, inexact=1. RNE → ∞; RTZ → max finite magnitude (exp all ones−1, fraction all ones), sign kept.

## Timing
- Reset values while rst=0: out_valid=0, out_z=0, all flags 0, state IDLE, in_ready=1 (combinational from IDLE).
- Reset mid-operation aborts the operation immediately and discards the result. No out_valid is produced.
- The accepting edge is edge 0; in_ready is 0 from the next cycle on.
- Special cases: out_valid=1 after edge 3.
- Normal path: out_valid=1 after edge 10 when the exponents are equal and there are no NORM_L/NORM_R shifts. Add 1 edge per ALIGN shift, per NORM_L shift and per NORM_R shift; a collapsed large-difference alignment adds 1 edge.
- out_z and flags are registered and stable while out_valid=1 and out_ready=0.
- On the edge where out_valid&&out_ready: out_valid→0 and state→IDLE. in_ready=1 the following cycle. No operand is accepted in the same cycle as the result handshake.

## Test plan
- Default params, 0x3F800000 + 0x40000000, RNE → out_z=0x40400000, flags 0, out_valid after edge 11.
- 0x3F800000 − 0x3F800000 (in_sub=1) → 0x00000000, flags 0. Then 0x7F800000 − 0x7F800000 → 0x7FC00000, invalid=1.
- 0x7F7FFFFF + 0x7F7FFFFF: RNE → 0x7F800000, overflow=1, inexact=1. RTZ → 0x7F7FFFFF, overflow=1, inexact=1.
- 0x00000001 + 0x00000001 → 0x00000002. Then 0x3F800000 + 0x33800000 RNE → 0x3F800000 with inexact=1 (tie to even).
- Hold out_ready=0 for 5 cycles → out_z and flags stable, in_ready=0. Drive rst=0 during ALIGN of a second op → out_valid=0 immediately; after release, in_ready=1 and the next op completes correctly.
- EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 → 0x4000. 0x7BFF + 0x7BFF RTZ → 0x7BFF, overflow=1.
